// File: rtl/djb2_stream_hash.sv
// Streaming djb2 / djb2a hash over a length-prefixed byte message.
// Bytes arrive on a valid/ready port; done pulses for one cycle once hash is final.
module djb2_stream_hash #(
    parameter int          HASH_W = 32,
    parameter int unsigned SEED   = 5381,
    parameter int          LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [HASH_W-1:0] hash
);

    localparam logic [HASH_W-1:0] SEED_H = HASH_W'(SEED);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [HASH_W-1:0]  hash_reg, hash_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic               mode_reg, mode_next;

    logic [HASH_W-1:0]  times33;
    logic [HASH_W-1:0]  data_ext;

    // h*33 as shift-and-add; the shifted-out bits are dropped by the modulo width.
    assign times33  = (hash_reg << 5) + hash_reg;
    assign data_ext = HASH_W'(in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            hash_reg  <= SEED_H;
            count_reg <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hash_reg  <= hash_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hash_next  = hash_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    count_next = len;
                    hash_next  = SEED_H;
                    state_next = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    hash_next  = mode_reg ? (times33 ^ data_ext) : (times33 + data_ext);
                    count_next = count_reg - LEN_W'(1);
                    // Leaving on the last beat keeps count from ever wrapping below zero.
                    if (count_reg == LEN_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hash = hash_reg;

endmodule

// File: doc/djb2_stream_hash.md
Name: djb2_stream_hash

Overview:
- Parametrised successor to the fixed three-byte djb2 block.
- Hashes a variable-length byte message, 0 to 2^LEN_W-1 bytes, streamed over a valid/ready interface.
- Configurable hash width and seed; run-time selectable djb2 (add) or djb2a (xor) combine.
- Sits between a byte producer (UART/FIFO) and a consumer that samples the hash on done.

Parameters:
HASH_W, 32, hash/accumulator width in bits (>= 8); all arithmetic is modulo 2^HASH_W.
SEED, 5381, initial hash value, truncated to HASH_W bits.
LEN_W, 8, width of the message-length input.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a new message; sampled only in IDLE.
len  input  LEN_W  message length in bytes; captured with start.
mode  input  1  0 = djb2 (h*33 + c), 1 = djb2a ((h*33) ^ c); captured with start.
in_valid  input  1  producer has a byte on in_data.
in_data  input  8  message byte.
in_ready  output  1  block accepts a byte this cycle.
busy  output  1  high in LOAD and DONE.
done  output  1  one-cycle pulse: hash is final.
hash  output  HASH_W  running/final hash; held until the next start.

Behaviour:
- Reset (async, any state): state=IDLE, hash=SEED, remaining count=0, mode register=0, in_ready=0, busy=0, done=0. Reset mid-message discards the message with no done pulse.
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0.
  - On start=1: capture len and mode, set hash<=SEED, count<=len.
  - If len!=0, go to LOAD. If len==0, go directly to DONE (hash=SEED).
- LOAD: in_ready=1 combinationally from state.
  - A beat is transferred when in_valid && in_ready.
  - Each beat: hash <= (hash<<5) + hash, then + in_data (mode 0) or ^ in_data (mode 1), zero-extended and truncated to HASH_W. count decrements.
  - Beat with count==1 → DONE next cycle.
  - No beat (in_valid=0): hold all state; stalls of any length are allowed.
- DONE: done=1 for exactly this one cycle, in_ready=0, then return to IDLE.
- Latency: done asserts the cycle after the last accepted beat (len==0: the cycle after start). The hash register already holds the final value in the done cycle.
- start while busy: ignored; len and mode are not re-captured. start in the DONE cycle is ignored; a new message may start the first IDLE cycle after.
- in_valid or in_data outside LOAD: ignored. hash keeps its last final value in IDLE.
- len=2^LEN_W-1: count must not wrap; exactly that many beats are consumed.

Test Plan:
1. Reset, then start, len=3, mode=0, bytes "abc" (0x61,0x62,0x63) back-to-back → in_ready high 3 cycles, done one cycle after third beat, hash=0x0B885C8B.
2. Same stimulus, mode=1 → hash=0x0B873285; repeat with in_valid gaps of 0–5 random cycles → identical hash, done only after the 3rd beat.
3. start, len=0 → no in_ready, done on the next cycle, hash=0x00001505; HASH_W=16 build with "abc", mode=0 → hash=0x5C8B.
4. Pulse start again during LOAD with different len/mode → ignored; original 3-byte result 0x0B885C8B, single done pulse.
5. Assert rst after 2 of 3 beats → immediately hash=0x00001505, busy=0, no done pulse; a fresh "abc" message then yields 0x0B885C8B.
6. len=255 with all bytes 0x00 and a producer holding in_valid=1 longer → exactly 255 beats accepted, in_ready low afterwards. Final hash equals the golden model (5381*33^255 mod 2^32).
